// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Write-back arbiter and load scoreboard for the register file's single write
// port. ALU results (single-cycle, buffered in a small FIFO) and load returns
// (variable latency) are merged into one registered write stream. Destinations
// of in-flight loads are tracked so decode can be stalled on hazards. Writes
// to x0 are dropped here and never reach the register file.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   alu_valid/alu_rd/alu_data   ALU result in;  alu_ready = FIFO not full
//   ld_issue/ld_issue_rd        load dispatch;  ld_issue_ready = dest not pending
//   ld_valid/ld_rd/ld_data      load return in; ld_ready = FIFO not full
//   rs1/rs2/rd_chk              registers of the instruction in decode
//   stall                       hazard flag for decode (combinational)
//   wb_we/wb_rd/wb_wdata        registered register-file write port
// -----------------------------------------------------------------------------
module wb_arbiter #(
  parameter int ALU_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        ld_issue,
  input  logic [4:0]  ld_issue_rd,
  output logic        ld_issue_ready,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd_chk,
  output logic        stall,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_wdata
);

  localparam int PTR_W = $clog2(ALU_DEPTH);

  // ALU result FIFO: payload arrays plus one valid bit per slot. Occupancy is
  // implied by the valid bits, so full/empty need no separate counter.
  logic [4:0]           rd_mem   [ALU_DEPTH];
  logic [31:0]          data_mem [ALU_DEPTH];
  logic [ALU_DEPTH-1:0] valid_reg, valid_next;
  logic [PTR_W-1:0]     head_reg, tail_reg;

  // Scoreboard; bit 0 exists only to allow direct indexing and stays 0.
  logic [31:0]          pend_reg, pend_next;

  logic        fifo_full, fifo_empty;
  logic        sel_head, sel_load, sel_bypass;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;
  logic        wb_write;
  logic        push, pop;
  logic        ld_accept, issue_set;

  assign fifo_full  = &valid_reg;
  assign fifo_empty = ~|valid_reg;

  assign alu_ready  = !fifo_full;
  assign ld_ready   = !fifo_full;

  assign ld_issue_ready = !(pend_reg[ld_issue_rd] && (ld_issue_rd != 5'd0));

  // Write-back source selection. A full FIFO takes precedence over loads so
  // the ALU path can never be starved indefinitely by back-to-back returns.
  always_comb begin
    sel_head   = fifo_full || (!ld_valid && !fifo_empty);
    sel_load   = !fifo_full && ld_valid;
    // Bypass: only when nothing else wants the port and no older ALU result
    // is queued, so ALU ordering is preserved.
    sel_bypass = fifo_empty && !ld_valid && alu_valid;
    sel_rd     = 5'd0;
    sel_data   = 32'd0;
    if (sel_head) begin
      sel_rd   = rd_mem[head_reg];
      sel_data = data_mem[head_reg];
    end else if (sel_load) begin
      sel_rd   = ld_rd;
      sel_data = ld_data;
    end else if (sel_bypass) begin
      sel_rd   = alu_rd;
      sel_data = alu_data;
    end
    wb_write = (sel_head || sel_load || sel_bypass) && (sel_rd != 5'd0);
  end

  // x0 results are accepted but never occupy a slot.
  assign push = alu_valid && alu_ready && (alu_rd != 5'd0) && !sel_bypass;
  assign pop  = sel_head;

  // Push and pop never touch the same slot: a push needs a free slot, and a
  // pop targets an occupied one.
  always_comb begin
    valid_next = valid_reg;
    if (pop)
      valid_next[head_reg] = 1'b0;
    if (push)
      valid_next[tail_reg] = 1'b1;
  end

  assign ld_accept = ld_valid && ld_ready;
  assign issue_set = ld_issue && ld_issue_ready && (ld_issue_rd != 5'd0);

  // Clear before set so a same-cycle issue to the returning register wins.
  // A return for a non-pending register simply clears an already-clear bit.
  always_comb begin
    pend_next = pend_reg;
    if (ld_accept)
      pend_next[ld_rd] = 1'b0;
    if (issue_set)
      pend_next[ld_issue_rd] = 1'b1;
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      pend_reg  <= '0;
    end else begin
      valid_reg <= valid_next;
      pend_reg  <= pend_next;
      if (pop)
        head_reg <= head_reg + 1'b1;
      if (push)
        tail_reg <= tail_reg + 1'b1;
    end
  end

  // Payload storage needs no reset: slots are only read while marked valid.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail_reg]   <= alu_rd;
      data_mem[tail_reg] <= alu_data;
    end
  end

  // Output stage. Address/data hold when no write happens.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_we    <= 1'b0;
      wb_rd    <= 5'd0;
      wb_wdata <= 32'd0;
    end else begin
      wb_we <= wb_write;
      if (wb_write) begin
        wb_rd    <= sel_rd;
        wb_wdata <= sel_data;
      end
    end
  end

  // Hazard detection for the three decode registers. The output stage is
  // included because the register file only commits on the following edge.
  logic [4:0] chk_addr [3];
  logic [2:0] busy;

  assign chk_addr[0] = rs1;
  assign chk_addr[1] = rs2;
  assign chk_addr[2] = rd_chk;

  genvar gi, gj;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chk
      logic [ALU_DEPTH-1:0] fifo_hit;
      for (gj = 0; gj < ALU_DEPTH; gj++) begin : g_ent
        assign fifo_hit[gj] = valid_reg[gj] && (rd_mem[gj] == chk_addr[gi]);
      end
      assign busy[gi] = (chk_addr[gi] != 5'd0) &&
                        (pend_reg[chk_addr[gi]] || (|fifo_hit) ||
                         (wb_we && (wb_rd == chk_addr[gi])));
    end
  endgenerate

  assign stall = |busy;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
// Directed testbench for wb_arbiter (ALU_DEPTH=2). Inputs are driven 1 time
// unit after each rising edge; combinational outputs are sampled shortly after
// driving, registered outputs 1 time unit after the following edge.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_issue_ready;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic [4:0]  rs1, rs2, rd_chk;
  logic        stall;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  wb_arbiter #(.ALU_DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .alu_valid      (alu_valid),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .alu_ready      (alu_ready),
    .ld_issue       (ld_issue),
    .ld_issue_rd    (ld_issue_rd),
    .ld_issue_ready (ld_issue_ready),
    .ld_valid       (ld_valid),
    .ld_rd          (ld_rd),
    .ld_data        (ld_data),
    .ld_ready       (ld_ready),
    .rs1            (rs1),
    .rs2            (rs2),
    .rd_chk         (rd_chk),
    .stall          (stall),
    .wb_we          (wb_we),
    .wb_rd          (wb_rd),
    .wb_wdata       (wb_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h (t=%0t)", tag, got, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid   = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    ld_issue    = 1'b0; ld_issue_rd = 5'd0;
    ld_valid    = 1'b0; ld_rd = 5'd0; ld_data = 32'd0;
  endtask

  // Arbitration table for the full-FIFO scenario: ld_valid held high while
  // three ALU results are pushed. Expected write order: 20,21,10,22,11,23,12.
  typedef struct {
    logic       lv;
    logic [4:0] lrd;
    logic       av;
    logic [4:0] ard;
    logic       exp_alu_ready;
    logic       exp_ld_ready;
    logic [4:0] exp_wb_rd;
  } arb_vec_t;

  arb_vec_t vecs [7];

  initial begin
    vecs[0] = '{1'b1, 5'd20, 1'b1, 5'd10, 1'b1, 1'b1, 5'd20};
    vecs[1] = '{1'b1, 5'd21, 1'b1, 5'd11, 1'b1, 1'b1, 5'd21};
    vecs[2] = '{1'b1, 5'd22, 1'b1, 5'd12, 1'b0, 1'b0, 5'd10};
    vecs[3] = '{1'b1, 5'd22, 1'b1, 5'd12, 1'b1, 1'b1, 5'd22};
    vecs[4] = '{1'b1, 5'd23, 1'b0, 5'd0,  1'b0, 1'b0, 5'd11};
    vecs[5] = '{1'b1, 5'd23, 1'b0, 5'd0,  1'b1, 1'b1, 5'd23};
    vecs[6] = '{1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 1'b1, 5'd12};

    // ---------------- reset ----------------
    reset = 1'b1;
    idle_inputs();
    rs1 = 5'd0; rs2 = 5'd0; rd_chk = 5'd0;
    step();
    step();
    reset = 1'b0;
    #1;
    check("rst_wb_we",          {31'd0, wb_we},          32'd0);
    check("rst_wb_rd",          {27'd0, wb_rd},          32'd0);
    check("rst_wb_wdata",       wb_wdata,                32'd0);
    check("rst_alu_ready",      {31'd0, alu_ready},      32'd1);
    check("rst_ld_issue_ready", {31'd0, ld_issue_ready}, 32'd1);
    check("rst_ld_ready",       {31'd0, ld_ready},       32'd1);
    check("rst_stall",          {31'd0, stall},          32'd0);

    // ---------------- ALU bypass ----------------
    step();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h11; rs1 = 5'd5;
    #1;
    check("byp_stall_before", {31'd0, stall}, 32'd0);
    step();
    idle_inputs();
    #1;
    check("byp_wb_we",    {31'd0, wb_we},  32'd1);
    check("byp_wb_rd",    {27'd0, wb_rd},  32'd5);
    check("byp_wb_wdata", wb_wdata,        32'h11);
    check("byp_stall_wb", {31'd0, stall},  32'd1);
    step();
    check("byp_wb_we_after", {31'd0, wb_we}, 32'd0);
    check("byp_stall_after", {31'd0, stall}, 32'd0);

    // ---------------- load scoreboard ----------------
    rs1 = 5'd0;
    ld_issue = 1'b1; ld_issue_rd = 5'd7;
    #1;
    check("ld_issue_ready_free", {31'd0, ld_issue_ready}, 32'd1);
    step();
    ld_issue = 1'b0;
    rs1 = 5'd7;
    #1;
    check("ld_pend_stall",       {31'd0, stall},          32'd1);
    check("ld_issue_ready_busy", {31'd0, ld_issue_ready}, 32'd0);
    step(); step(); step();
    check("ld_pend_stall_hold",  {31'd0, stall},          32'd1);
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'hABCD;
    #1;
    check("ld_ready_return", {31'd0, ld_ready}, 32'd1);
    step();
    idle_inputs();
    #1;
    check("ld_wb_we",       {31'd0, wb_we},          32'd1);
    check("ld_wb_rd",       {27'd0, wb_rd},          32'd7);
    check("ld_wb_wdata",    wb_wdata,                32'hABCD);
    check("ld_stall_wb",    {31'd0, stall},          32'd1);
    ld_issue_rd = 5'd7;
    #1;
    check("ld_issue_ready_cleared", {31'd0, ld_issue_ready}, 32'd1);
    ld_issue_rd = 5'd0;
    step();
    check("ld_stall_after", {31'd0, stall}, 32'd0);

    // ---------------- load vs ALU same cycle ----------------
    rs1 = 5'd4;
    ld_valid  = 1'b1; ld_rd  = 5'd3; ld_data  = 32'h33;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
    #1;
    check("mix_alu_ready", {31'd0, alu_ready}, 32'd1);
    step();
    idle_inputs();
    #1;
    check("mix_first_rd",     {27'd0, wb_rd},     32'd3);
    check("mix_first_data",   wb_wdata,           32'h33);
    check("mix_alu_ready_q",  {31'd0, alu_ready}, 32'd1);
    check("mix_stall_queued", {31'd0, stall},     32'd1);
    step();
    check("mix_second_we",   {31'd0, wb_we}, 32'd1);
    check("mix_second_rd",   {27'd0, wb_rd}, 32'd4);
    check("mix_second_data", wb_wdata,       32'h44);
    step();
    check("mix_idle_we", {31'd0, wb_we}, 32'd0);
    rs1 = 5'd0;

    // ---------------- full FIFO arbitration ----------------
    for (int i = 0; i < 7; i++) begin
      ld_valid  = vecs[i].lv;
      ld_rd     = vecs[i].lrd;
      ld_data   = 32'h1000 + {27'd0, vecs[i].lrd};
      alu_valid = vecs[i].av;
      alu_rd    = vecs[i].ard;
      alu_data  = 32'h2000 + {27'd0, vecs[i].ard};
      #1;
      check($sformatf("arb%0d_alu_ready", i), {31'd0, alu_ready}, {31'd0, vecs[i].exp_alu_ready});
      check($sformatf("arb%0d_ld_ready", i),  {31'd0, ld_ready},  {31'd0, vecs[i].exp_ld_ready});
      step();
      check($sformatf("arb%0d_wb_we", i), {31'd0, wb_we}, 32'd1);
      check($sformatf("arb%0d_wb_rd", i), {27'd0, wb_rd}, {27'd0, vecs[i].exp_wb_rd});
      check($sformatf("arb%0d_wb_wdata", i), wb_wdata,
            ((vecs[i].exp_wb_rd >= 5'd20) ? 32'h1000 : 32'h2000) + {27'd0, vecs[i].exp_wb_rd});
    end
    idle_inputs();
    step();
    check("arb_drained_we",    {31'd0, wb_we},     32'd0);
    check("arb_drained_ready", {31'd0, alu_ready}, 32'd1);

    // ---------------- x0 requests ----------------
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
      ld_valid  = (i != 0); ld_rd = 5'd0; ld_data = 32'hBEEF;
      ld_issue  = 1'b1; ld_issue_rd = 5'd0;
      #1;
      check($sformatf("x0_%0d_alu_ready", i), {31'd0, alu_ready},      32'd1);
      check($sformatf("x0_%0d_issue_rdy", i), {31'd0, ld_issue_ready}, 32'd1);
      check($sformatf("x0_%0d_stall", i),     {31'd0, stall},          32'd0);
      step();
      check($sformatf("x0_%0d_wb_we", i), {31'd0, wb_we}, 32'd0);
    end
    idle_inputs();
    #1;
    check("x0_alu_ready_end", {31'd0, alu_ready}, 32'd1);
    step();
    check("x0_no_queued_write", {31'd0, wb_we}, 32'd0);

    // ---------------- reset mid-operation ----------------
    ld_issue = 1'b1; ld_issue_rd = 5'd9;
    ld_valid = 1'b1; ld_rd = 5'd20; ld_data = 32'h20;
    alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'h13;
    step();
    ld_issue = 1'b0;
    ld_rd = 5'd21; ld_data = 32'h21;
    alu_rd = 5'd14; alu_data = 32'h14;
    step();
    idle_inputs();
    rs1 = 5'd9;
    #1;
    check("mid_full_alu_ready", {31'd0, alu_ready}, 32'd0);
    check("mid_pend_stall",     {31'd0, stall},     32'd1);
    reset = 1'b1;
    #1;
    check("mid_async_alu_ready", {31'd0, alu_ready}, 32'd1);
    check("mid_async_wb_we",     {31'd0, wb_we},     32'd0);
    check("mid_async_stall",     {31'd0, stall},     32'd0);
    step();
    reset = 1'b0;
    #1;
    check("mid_rel_stall",        {31'd0, stall},     32'd0);
    check("mid_rel_alu_ready",    {31'd0, alu_ready}, 32'd1);
    ld_issue_rd = 5'd9;
    #1;
    check("mid_rel_issue_ready",  {31'd0, ld_issue_ready}, 32'd1);
    ld_issue_rd = 5'd0;
    step();
    check("mid_rel_wb_we",        {31'd0, wb_we},     32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
